// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared types and constants for the 7-segment display driver.
//                It holds the converter state type, the traffic-light codes,
//                the blank pattern and the BCD-to-segment encoder.
//  Revision    : 1.0  initial release
// ============================================================================
package seg_pkg;

  // State of the sequential binary-to-BCD converter
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_e;

  // Light codes: {red, yellow, green}, one-hot
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_OFF    = 3'b000;

  // All segments off (active-low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Largest value the two-digit display can show
  localparam int unsigned MAX_DISP = 99;

  // BCD nibble to active-low gfedcba pattern; non-BCD codes are blanked
  function automatic logic [6:0] seg_enc(input logic [3:0] nibble);
    logic [6:0] pat;
    case (nibble)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage : seg_pkg
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble converter. It clamps the input to
//                99. When the clamped value differs from the last converted
//                value, it runs VAL_W shift cycles and then loads the two
//                BCD digits. Input changes during a conversion are ignored.
//                The next IDLE cycle compares the input again, so the final
//                value is always converted.
//  Revision    : 1.0  initial release
// ============================================================================
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int VAL_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VAL_W-1:0] value_i,
  output logic             start_o,
  output logic             busy_o,
  output logic [3:0]       tens_o,
  output logic [3:0]       ones_o
);

  // Shift register layout: {tens nibble, ones nibble, binary operand}
  localparam int SR_W  = VAL_W + 8;
  localparam int CNT_W = $clog2(VAL_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(VAL_W - 1);

  state_e            state_q, state_d;
  logic [VAL_W-1:0]  latched_q;
  logic [SR_W-1:0]   sr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic [3:0]        tens_q, ones_q;

  logic [VAL_W-1:0]  clamped_w;
  logic              changed_w;
  logic [SR_W-1:0]   adj_w;
  logic [SR_W-1:0]   shift_w;

  // Saturate values above 99 so the result always fits in two digits
  always_comb begin
    clamped_w = value_i;
    if (value_i > VAL_W'(MAX_DISP)) begin
      clamped_w = VAL_W'(MAX_DISP);
    end
    changed_w = (clamped_w != latched_q);
  end

  // One double-dabble step: add 3 to each nibble >= 5, then shift left
  always_comb begin
    adj_w = sr_q;
    if (sr_q[VAL_W+3:VAL_W] >= 4'd5) begin
      adj_w[VAL_W+3:VAL_W] = sr_q[VAL_W+3:VAL_W] + 4'd3;
    end
    if (sr_q[VAL_W+7:VAL_W+4] >= 4'd5) begin
      adj_w[VAL_W+7:VAL_W+4] = sr_q[VAL_W+7:VAL_W+4] + 4'd3;
    end
    shift_w = adj_w << 1;
  end

  // State register; reset drops any conversion that is in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> CONV (VAL_W cycles) -> LOAD -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (changed_w) state_d = CONV;
      CONV:    if (cnt_q == LAST_STEP) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: start pulses in the IDLE cycle that accepts a new value
  always_comb begin
    start_o = (state_q == IDLE) && changed_w;
  end

  // Datapath: latch the operand, run the shift steps, publish the digits
  always_ff @(posedge clk) begin
    if (rst) begin
      latched_q <= '0;
      sr_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (changed_w) begin
            latched_q <= clamped_w;
            sr_q      <= {8'd0, clamped_w};
            cnt_q     <= '0;
            busy_q    <= 1'b1;
          end
        end
        CONV: begin
          sr_q  <= shift_w;
          cnt_q <= cnt_q + 1'b1;
        end
        LOAD: begin
          tens_q <= sr_q[VAL_W+7:VAL_W+4];
          ones_q <= sr_q[VAL_W+3:VAL_W];
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign tens_o = tens_q;
  assign ones_o = ones_q;

endmodule : bin2bcd_seq
`default_nettype wire

// File: rtl/seg_display_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg_display_driver
//  Description : Converts the countdown value into two BCD digits. It
//                time-multiplexes the digits onto a common-anode 7-segment
//                pair and decodes the phase select into one-hot lights.
//                Optional build macro: SEG_BLANK_LEADING_ZERO_EN. When it is
//                defined, a zero tens digit is shown blank.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_display_driver
  import seg_pkg::*;
#(
  parameter int SCAN_W = 16,
  parameter int VAL_W  = 7
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             En,
  input  logic [VAL_W-1:0] Q_in,
  input  logic [1:0]       select_in,
  output logic [6:0]       seg,
  output logic [1:0]       an,
  output logic [2:0]       light,
  output logic             busy
);

  logic [SCAN_W-1:0] scan_q;
  logic [6:0]        seg_q;
  logic [1:0]        an_q;
  logic [2:0]        light_q;

  logic              conv_start_w;
  logic [3:0]        tens_w, ones_w;
  logic [6:0]        tens_seg_w, ones_seg_w;

  bin2bcd_seq #(
    .VAL_W   (VAL_W)
  ) u_conv (
    .clk     (CLK),
    .rst     (RST),
    .value_i (Q_in),
    .start_o (conv_start_w),
    .busy_o  (busy),
    .tens_o  (tens_w),
    .ones_o  (ones_w)
  );

  // Segment patterns for each digit slot, with optional leading-zero blanking
  always_comb begin
    ones_seg_w = seg_enc(ones_w);
`ifdef SEG_BLANK_LEADING_ZERO_EN
    tens_seg_w = (tens_w == 4'd0) ? SEG_BLANK : seg_enc(tens_w);
`else
    tens_seg_w = seg_enc(tens_w);
`endif
  end

  // Free-running scan counter; held at zero while the display is disabled
  always_ff @(posedge CLK) begin
    if (RST || !En) begin
      scan_q <= '0;
    end else begin
      scan_q <= scan_q + 1'b1;
    end
  end

  // Registered anode/segment mux, one cycle behind the scan counter
  always_ff @(posedge CLK) begin
    if (RST || !En) begin
      seg_q <= SEG_BLANK;
      an_q  <= 2'b11;
    end else if (!scan_q[SCAN_W-1]) begin
      seg_q <= ones_seg_w;
      an_q  <= 2'b10;
    end else begin
      seg_q <= tens_seg_w;
      an_q  <= 2'b01;
    end
  end

  // Registered light decode; invalid phase codes turn all lights off
  always_ff @(posedge CLK) begin
    if (RST) begin
      light_q <= LIGHT_OFF;
    end else begin
      case (select_in)
        2'b00:   light_q <= LIGHT_GREEN;
        2'b01:   light_q <= LIGHT_YELLOW;
        2'b11:   light_q <= LIGHT_RED;
        default: light_q <= LIGHT_OFF;
      endcase
    end
  end

  // The start pulse is not needed here; fold it away explicitly
  logic unused_w;
  assign unused_w = conv_start_w;

  assign seg   = seg_q;
  assign an    = an_q;
  assign light = light_q;

endmodule : seg_display_driver
`default_nettype wire

// File: tb/tb_seg_display_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_display_driver
//  Description : Directed self-checking bench for seg_display_driver. It
//                uses a short scan counter so both digit slots appear
//                within a few cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg_display_driver;

  localparam int SCAN_W = 4;
  localparam int VAL_W  = 7;
  localparam int HALF   = 1 << (SCAN_W - 1);

  logic             CLK = 1'b0;
  logic             RST;
  logic             En;
  logic [VAL_W-1:0] Q_in;
  logic [1:0]       select_in;
  logic [6:0]       seg;
  logic [1:0]       an;
  logic [2:0]       light;
  logic             busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [6:0] t;
    logic [6:0] o;
  } disp_t;

  disp_t      q_disp[$];
  logic [2:0] q_light[$];

  seg_display_driver #(
    .SCAN_W    (SCAN_W),
    .VAL_W     (VAL_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .En        (En),
    .Q_in      (Q_in),
    .select_in (select_in),
    .seg       (seg),
    .an        (an),
    .light     (light),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  // Reference segment table (active-low gfedcba)
  function automatic logic [6:0] ref_enc(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return tbl[d];
  endfunction

  function automatic disp_t ref_disp(input int value);
    disp_t d;
    int v;
    v = (value > 99) ? 99 : value;
`ifdef SEG_BLANK_LEADING_ZERO_EN
    d.t = (v / 10 == 0) ? 7'h7F : ref_enc(v / 10);
`else
    d.t = ref_enc(v / 10);
`endif
    d.o = ref_enc(v % 10);
    return d;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    chk({tag, "_idle"}, {15'd0, busy}, 16'd0);
  endtask

  // Collect the pattern shown in each digit slot, then check it against the scoreboard
  task automatic check_disp(input string tag);
    logic [6:0] t = '0;
    logic [6:0] o = '0;
    bit gt = 0;
    bit go = 0;
    disp_t e;
    for (int i = 0; i < 4 * HALF && !(gt && go); i++) begin
      if (an == 2'b01) begin
        t = seg; gt = 1;
      end else if (an == 2'b10) begin
        o = seg; go = 1;
      end
      if (!(gt && go)) tick();
    end
    chk({tag, "_slots_seen"}, {14'd0, gt, go}, 16'd3);
    e = q_disp.pop_front();
    chk({tag, "_tens"}, {9'd0, t}, {9'd0, e.t});
    chk({tag, "_ones"}, {9'd0, o}, {9'd0, e.o});
  endtask

  task automatic light_step(input logic [1:0] sel, input logic [2:0] exp, input string tag);
    select_in = sel;
    q_light.push_back(exp);
    tick();
    chk(tag, {13'd0, light}, {13'd0, q_light.pop_front()});
  endtask

  initial begin
    int n;
    // 1: reset
    RST = 1'b1; En = 1'b1; Q_in = '0; select_in = 2'b10;
    tick(); tick();
    chk("rst_seg",   {9'd0, seg},   16'h7F);
    chk("rst_an",    {14'd0, an},   16'd3);
    chk("rst_light", {13'd0, light}, 16'd0);
    chk("rst_busy",  {15'd0, busy}, 16'd0);
    RST = 1'b0;
    q_disp.push_back(ref_disp(0));
    tick();
    check_disp("zero");

    // 2: conversion latency
    Q_in = 7'd57;
    q_disp.push_back(ref_disp(57));
    tick();
    n = 0;
    while (busy && n < 30) begin
      n++;
      tick();
    end
    chk("busy_cycles_57", 16'(n), 16'd8);
    tick();
    check_disp("d57");

    // 3: saturation, then a change during conversion
    Q_in = 7'd120;
    q_disp.push_back(ref_disp(120));
    tick();
    wait_idle("sat");
    tick();
    check_disp("sat99");

    Q_in = 7'd30;
    q_disp.push_back(ref_disp(30));
    tick();
    chk("busy_30", {15'd0, busy}, 16'd1);
    tick(); tick();
    Q_in = 7'd12;
    q_disp.push_back(ref_disp(12));
    wait_idle("c30");
    tick();
    check_disp("d30");
    repeat (12) tick();
    wait_idle("c12");
    check_disp("d12");

    // 4: lights
    light_step(2'b00, 3'b001, "light_00");
    light_step(2'b01, 3'b010, "light_01");
    light_step(2'b11, 3'b100, "light_11");
    light_step(2'b10, 3'b000, "light_10");

    // 5: enable off, lights independent of enable, scan held at zero
    En = 1'b0;
    light_step(2'b01, 3'b010, "light_en0");
    chk("en0_an",  {14'd0, an}, 16'd3);
    chk("en0_seg", {9'd0, seg}, 16'h7F);
    repeat (5) tick();
    chk("en0_an_hold", {14'd0, an}, 16'd3);
    En = 1'b1;
    tick();
    n = 0;
    while (an == 2'b10 && n < 4 * HALF) begin
      n++;
      tick();
    end
    chk("scan_restart_ones_len", 16'(n), 16'(HALF));
    chk("scan_then_tens", {14'd0, an}, 16'd1);

    // reset during a conversion
    Q_in = 7'd45;
    tick();
    chk("busy_45", {15'd0, busy}, 16'd1);
    tick(); tick(); tick();
    RST = 1'b1; Q_in = '0;
    tick();
    RST = 1'b0;
    chk("midrst_busy", {15'd0, busy}, 16'd0);
    chk("midrst_an",   {14'd0, an},   16'd3);
    chk("midrst_seg",  {9'd0, seg},   16'h7F);
    q_disp.push_back(ref_disp(0));
    n = 0;
    repeat (12) begin
      tick();
      if (busy) n++;
    end
    chk("midrst_no_conv", 16'(n), 16'd0);
    check_disp("midrst_digits");

    // 6: single-digit value (leading zero)
    Q_in = 7'd5;
    q_disp.push_back(ref_disp(5));
    tick();
    wait_idle("c5");
    tick();
    check_disp("d05");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seg_display_driver
`default_nettype wire
